// File: rtl/up_counter_5bit_ctl.sv
// 5-bit up counter with start/run/done control, programmable terminal value,
// parallel load, terminal-count flag and sticky free-run overflow flag.
module up_counter_5bit_ctl #(
  parameter int WIDTH    = 5,
  parameter int TERMINAL = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic             en,
  input  logic             oneshot,
  output logic [WIDTH-1:0] o,
  output logic             busy,
  output logic             done,
  output logic             tc,
  output logic             ovf
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] TERM_C = WIDTH'(TERMINAL);
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_C = WIDTH'(0);

  state_t           state_r, state_s;
  logic [WIDTH-1:0] cnt_r, cnt_s;
  logic             ovf_r, ovf_s;
  logic             busy_r, done_r, tc_r;

  // next-state and next-count decode: clr beats load beats the FSM
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    ovf_s   = ovf_r;
    if (clr) begin
      state_s = ST_IDLE;
      cnt_s   = ZERO_C;
      ovf_s   = 1'b0;
    end else if (load) begin
      cnt_s = d;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (en) begin
            if (cnt_r == TERM_C) begin
              if (oneshot) begin
                state_s = ST_DONE;
              end else begin
                cnt_s = ZERO_C;
                ovf_s = 1'b1;
              end
            end else begin
              cnt_s = cnt_r + ONE_C;
            end
          end else begin
            cnt_s = cnt_r;
          end
        end
        ST_DONE: begin
          if (start) begin
            state_s = ST_RUN;
            cnt_s   = ZERO_C;
          end else begin
            state_s = ST_DONE;
          end
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = ZERO_C;
        end
      endcase
    end
  end

  // state, count and status flags; flags are registered from the next-state
  // decode so they line up with the state register on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= ZERO_C;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      tc_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ovf_r   <= ovf_s;
      busy_r  <= (state_s == ST_RUN);
      done_r  <= (state_s == ST_DONE);
      tc_r    <= (state_s == ST_RUN) && (cnt_s == TERM_C);
    end
  end

  assign o    = cnt_r;
  assign busy = busy_r;
  assign done = done_r;
  assign tc   = tc_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_up_counter_5bit_ctl.sv
// Directed bench for up_counter_5bit_ctl: two instances (terminal 31 and 9)
// share stimulus and are checked every cycle against a behavioural model.
module tb_up_counter_5bit_ctl;

  localparam int W  = 5;
  localparam int T0 = 31;
  localparam int T1 = 9;

  if (T0 > (1 << W) - 1 || T1 > (1 << W) - 1) begin : g_term_chk
    $error("TERMINAL exceeds 2**WIDTH-1");
  end

  logic         clk;
  logic         rst;
  logic         clr, load, start, en, oneshot;
  logic [W-1:0] d;
  logic [W-1:0] o0, o1;
  logic         busy0, done0, tc0, ovf0;
  logic         busy1, done1, tc1, ovf1;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  up_counter_5bit_ctl #(.WIDTH(W), .TERMINAL(T0)) dut (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .d(d), .start(start),
    .en(en), .oneshot(oneshot), .o(o0), .busy(busy0), .done(done0),
    .tc(tc0), .ovf(ovf0)
  );

  up_counter_5bit_ctl #(.WIDTH(W), .TERMINAL(T1)) dut9 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .d(d), .start(start),
    .en(en), .oneshot(oneshot), .o(o1), .busy(busy1), .done(done1),
    .tc(tc1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model: counter value plus "running"/"finished" mode flags
  int m_cnt[2];
  bit m_running[2], m_finished[2], m_ovf[2];
  int m_term[2] = '{T0, T1};

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_cnt[i] = 0; m_running[i] = 0; m_finished[i] = 0; m_ovf[i] = 0;
      end else if (clr) begin
        m_cnt[i] = 0; m_running[i] = 0; m_finished[i] = 0; m_ovf[i] = 0;
      end else if (load) begin
        m_cnt[i] = int'(d);
      end else if (m_running[i]) begin
        if (en && m_cnt[i] == m_term[i]) begin
          if (oneshot) begin
            m_running[i] = 0; m_finished[i] = 1;
          end else begin
            m_cnt[i] = 0; m_ovf[i] = 1;
          end
        end else if (en) begin
          m_cnt[i] = (m_cnt[i] + 1) % (1 << W);
        end
      end else if (start) begin
        if (m_finished[i]) m_cnt[i] = 0;
        m_running[i] = 1; m_finished[i] = 0;
      end
    end
  end

  // per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int ao, eo;
        bit ab, ad, at, av, eb, ed, et, ev;
        ao = (i == 0) ? int'(o0) : int'(o1);
        ab = (i == 0) ? busy0 : busy1;
        ad = (i == 0) ? done0 : done1;
        at = (i == 0) ? tc0   : tc1;
        av = (i == 0) ? ovf0  : ovf1;
        eo = m_cnt[i];
        eb = m_running[i];
        ed = m_finished[i];
        et = m_running[i] && (m_cnt[i] == m_term[i]);
        ev = m_ovf[i];
        n_chk++;
        if (ao != eo || ab != eb || ad != ed || at != et || av != ev) begin
          n_fail++;
          $display("FAIL model_t%0d @%0t: o=%0d busy=%0b done=%0b tc=%0b ovf=%0b, expected o=%0d busy=%0b done=%0b tc=%0b ovf=%0b",
                   m_term[i], $time, ao, ab, ad, at, av, eo, eb, ed, et, ev);
        end
      end
    end
  end

  task automatic lit(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; load = 1'b0; start = 1'b0; en = 1'b0;
    oneshot = 1'b0; d = 5'd0;
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    lit("rst_o", int'(o0), 0);
    lit("rst_busy", int'(busy0), 0);
    lit("rst_done", int'(done0), 0);
    lit("rst_ovf", int'(ovf0), 0);
    #9 rst = 1'b0;

    // 1: free-run wrap with sticky ovf
    start = 1'b1; en = 1'b1; tick(1); start = 1'b0;
    lit("t1_start_o", int'(o0), 0);
    lit("t1_start_busy", int'(busy0), 1);
    tick(31);
    lit("t1_o31", int'(o0), 31);
    lit("t1_tc31", int'(tc0), 1);
    lit("t1_ovf_pre", int'(ovf0), 0);
    tick(1);
    lit("t1_wrap_o", int'(o0), 0);
    lit("t1_wrap_ovf", int'(ovf0), 1);
    lit("t1_wrap_tc", int'(tc0), 0);
    tick(1);
    lit("t1_after_o", int'(o0), 1);

    // 2: one-shot stop at terminal, restart from DONE
    clr = 1'b1; tick(1); clr = 1'b0;
    oneshot = 1'b1;
    start = 1'b1; tick(1); start = 1'b0;
    tick(31);
    lit("t2_o31", int'(o0), 31);
    lit("t2_busy31", int'(busy0), 1);
    tick(1);
    lit("t2_done", int'(done0), 1);
    lit("t2_busy0", int'(busy0), 0);
    tick(10);
    lit("t2_hold_o", int'(o0), 31);
    lit("t2_hold_done", int'(done0), 1);
    start = 1'b1; tick(1); start = 1'b0;
    lit("t2_restart_o", int'(o0), 0);
    lit("t2_restart_busy", int'(busy0), 1);

    // 3: load during RUN, hold with en low, wrap from loaded value
    tick(7);
    lit("t3_o7", int'(o0), 7);
    oneshot = 1'b0;
    load = 1'b1; d = 5'd28; tick(1); load = 1'b0;
    lit("t3_load_o", int'(o0), 28);
    tick(1);
    en = 1'b0; tick(3);
    lit("t3_hold_o", int'(o0), 29);
    en = 1'b1; tick(2);
    lit("t3_o31", int'(o0), 31);
    tick(1);
    lit("t3_wrap_o", int'(o0), 0);
    lit("t3_wrap_ovf", int'(ovf0), 1);

    // 4: clr beats coincident load and start
    clr = 1'b1; load = 1'b1; d = 5'd12; start = 1'b1; tick(1);
    clr = 1'b0; load = 1'b0; start = 1'b0;
    lit("t4_o", int'(o0), 0);
    lit("t4_busy", int'(busy0), 0);
    lit("t4_ovf", int'(ovf0), 0);
    tick(1);
    lit("t4_idle_o", int'(o0), 0);

    // 5: asynchronous reset between edges
    start = 1'b1; tick(1); start = 1'b0;
    tick(13);
    lit("t5_o13", int'(o0), 13);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    lit("t5_async_o", int'(o0), 0);
    lit("t5_async_busy", int'(busy0), 0);
    lit("t5_async_ovf", int'(ovf0), 0);
    #1 rst = 1'b0;
    tick(3);
    lit("t5_idle_o", int'(o0), 0);

    // 6: terminal 9 instance, wrap and load above terminal
    clr = 1'b1; tick(1); clr = 1'b0;
    start = 1'b1; tick(1); start = 1'b0;
    tick(9);
    lit("t6_o9", int'(o1), 9);
    lit("t6_tc9", int'(tc1), 1);
    lit("t6_ovf_pre", int'(ovf1), 0);
    tick(1);
    lit("t6_wrap_o", int'(o1), 0);
    lit("t6_wrap_ovf", int'(ovf1), 1);
    clr = 1'b1; tick(1); clr = 1'b0;
    start = 1'b1; tick(1); start = 1'b0;
    load = 1'b1; d = 5'd20; tick(1); load = 1'b0;
    lit("t6_load_o", int'(o1), 20);
    tick(11);
    lit("t6_o31", int'(o1), 31);
    tick(1);
    lit("t6_max_wrap_o", int'(o1), 0);
    lit("t6_max_wrap_ovf", int'(ovf1), 0);
    tick(9);
    lit("t6_o9b", int'(o1), 9);
    tick(1);
    lit("t6_term_wrap_o", int'(o1), 0);
    lit("t6_term_wrap_ovf", int'(ovf1), 1);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
